// File: rtl/seq_mult_hs.sv
// Iterative shift-add multiplier with ready/valid on both sides; retires K
// multiplier bits per cycle and supports per-operation signed/unsigned mode.
module seq_mult_hs #(
   parameter  int A_W = 16,
   parameter  int B_W = 8,
   parameter  int K   = 2,
   localparam int P_W = A_W + B_W
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_vld,
   output logic           in_rdy,
   input  logic [A_W-1:0] a,
   input  logic [B_W-1:0] b,
   input  logic           is_signed,
   output logic           out_vld,
   input  logic           out_rdy,
   output logic [P_W-1:0] p,
   output logic           busy
);

   localparam int S      = B_W / K;
   localparam int STEP_W = (S > 1) ? $clog2(S) : 1;
   localparam logic [STEP_W-1:0] LAST = STEP_W'(S - 1);

   if (B_W % K != 0) begin : g_bad_k
      $error("seq_mult_hs: B_W must be a multiple of K");
   end

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t            state_q, state_d;
   logic [P_W-1:0]    acc_q, acc_d;
   logic [P_W-1:0]    a_sh_q, a_sh_d;
   logic [B_W-1:0]    b_sh_q, b_sh_d;
   logic              sgn_q, sgn_d;
   logic [STEP_W-1:0] step_q, step_d;
   logic [P_W-1:0]    p_q, p_d;
   logic [P_W-1:0]    a_ext;
   logic [P_W-1:0]    part;

   assign a_ext = {{B_W{is_signed & a[A_W-1]}}, a};

   // Multiplicand is pre-shifted each step, so bit j of the shifted
   // multiplier always weighs a_sh << j; the MSB of b is negative in signed mode.
   always_comb begin
      part = '0;
      for (int j = 0; j < K; j++) begin
         if (b_sh_q[j]) begin
            if (sgn_q && (step_q == LAST) && (j == K - 1)) part = part - (a_sh_q << j);
            else                                           part = part + (a_sh_q << j);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      sgn_d   = sgn_q;
      step_d  = step_q;
      p_d     = p_q;
      case (state_q)
         IDLE: begin
            if (in_vld) begin
               a_sh_d  = a_ext;
               b_sh_d  = b;
               sgn_d   = is_signed;
               acc_d   = '0;
               step_d  = '0;
               state_d = CALC;
            end
         end
         CALC: begin
            acc_d  = acc_q + part;
            a_sh_d = a_sh_q << K;
            b_sh_d = b_sh_q >> K;
            step_d = step_q + 1'b1;
            if (step_q == LAST) begin
               p_d     = acc_q + part;
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_rdy) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         acc_q   <= '0;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         sgn_q   <= 1'b0;
         step_q  <= '0;
         p_q     <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         sgn_q   <= sgn_d;
         step_q  <= step_d;
         p_q     <= p_d;
      end
   end

   assign in_rdy  = (state_q == IDLE) & ~rst;
   assign busy    = (state_q != IDLE);
   assign out_vld = (state_q == DONE);
   assign p       = p_q;

endmodule

// File: tb/tb_seq_mult_hs.sv
// Bench for seq_mult_hs: directed and random runs on the default build,
// plus exhaustive sweeps of two small builds (K=1 and K=4) running alongside.
module tb_seq_mult_hs;

   localparam int A_W = 16;
   localparam int B_W = 8;
   localparam int P_W = 24;
   localparam int S   = 4;

   logic           clk = 1'b0;
   logic           rst;
   logic           rst_sw = 1'b1;
   logic           in_vld, in_rdy, is_signed, out_vld, out_rdy, busy;
   logic [A_W-1:0] a;
   logic [B_W-1:0] b;
   logic [P_W-1:0] p;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
   endtask

   // Reference product: interpret operands as integers, multiply, wrap to aw+bw bits.
   function automatic longint ref_mul(input longint av, input longint bv, input bit sv,
                                      input int aw, input int bw);
      longint x, y;
      x = av;
      y = bv;
      if (sv && av[aw-1]) x = av - (longint'(1) << aw);
      if (sv && bv[bw-1]) y = bv - (longint'(1) << bw);
      return (x * y) & ((longint'(1) << (aw + bw)) - 1);
   endfunction

   seq_mult_hs #(.A_W(A_W), .B_W(B_W), .K(2)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .in_vld   (in_vld),
      .in_rdy   (in_rdy),
      .a        (a),
      .b        (b),
      .is_signed(is_signed),
      .out_vld  (out_vld),
      .out_rdy  (out_rdy),
      .p        (p),
      .busy     (busy)
   );

   for (genvar g = 0; g < 2; g++) begin : g_sw
      localparam int KK = (g == 0) ? 1 : 4;
      localparam int SS = 4 / KK;
      logic        in_vld_s, in_rdy_s, is_signed_s, out_vld_s, out_rdy_s, busy_s;
      logic [7:0]  a_s;
      logic [3:0]  b_s;
      logic [11:0] p_s;
      bit          sw_done = 1'b0;

      seq_mult_hs #(.A_W(8), .B_W(4), .K(KK)) u_sw (
         .clk      (clk),
         .rst      (rst_sw),
         .in_vld   (in_vld_s),
         .in_rdy   (in_rdy_s),
         .a        (a_s),
         .b        (b_s),
         .is_signed(is_signed_s),
         .out_vld  (out_vld_s),
         .out_rdy  (out_rdy_s),
         .p        (p_s),
         .busy     (busy_s)
      );

      initial begin : sweep
         int n, m;
         in_vld_s = 1'b0; out_rdy_s = 1'b0; a_s = '0; b_s = '0; is_signed_s = 1'b0;
         @(negedge rst_sw);
         @(negedge clk);
         for (int sv = 0; sv < 2; sv++) begin
            for (int ai = 0; ai < 256; ai++) begin
               for (int bi = 0; bi < 16; bi++) begin
                  a_s = 8'(ai); b_s = 4'(bi); is_signed_s = sv[0]; in_vld_s = 1'b1;
                  n = 0;
                  while (!in_rdy_s && n < 20) begin @(negedge clk); n++; end
                  if (n >= 20) chk($sformatf("sw%0d_rdy", g), in_rdy_s, 1);
                  @(negedge clk);
                  in_vld_s = 1'b0;
                  m = 0;
                  while (!out_vld_s && m < 20) begin
                     out_rdy_s = 1'($urandom_range(1));
                     @(negedge clk);
                     m++;
                  end
                  out_rdy_s = 1'b0;
                  chk($sformatf("sw%0d_lat", g), m, SS);
                  if ($urandom_range(3) == 0) repeat ($urandom_range(3, 1)) @(negedge clk);
                  chk($sformatf("sw%0d_p", g), p_s, ref_mul(ai, bi, sv[0], 8, 4));
                  out_rdy_s = 1'b1;
                  @(negedge clk);
                  out_rdy_s = 1'b0;
               end
            end
         end
         sw_done = 1'b1;
      end
   end

   task automatic run_op(input logic [A_W-1:0] av, input logic [B_W-1:0] bv, input bit sv,
                         input int stall, output logic [P_W-1:0] pv);
      int n, m;
      bit busy_ok;
      @(negedge clk);
      a = av; b = bv; is_signed = sv; in_vld = 1'b1;
      n = 0;
      while (!in_rdy && n < 20) begin @(negedge clk); n++; end
      if (n >= 20) chk("op_rdy", in_rdy, 1);
      @(negedge clk);
      in_vld = 1'b0;
      a = A_W'($urandom); b = B_W'($urandom); is_signed = 1'($urandom_range(1));
      m = 0;
      busy_ok = 1'b1;
      while (!out_vld && m < 20) begin
         if (!busy) busy_ok = 1'b0;
         out_rdy = 1'($urandom_range(1));
         @(negedge clk);
         m++;
      end
      out_rdy = 1'b0;
      chk("op_lat", m, S);
      chk("op_busy", busy_ok, 1);
      repeat (stall) @(negedge clk);
      pv = p;
      out_rdy = 1'b1;
      @(negedge clk);
      out_rdy = 1'b0;
      chk("op_vld_drop", out_vld, 0);
   endtask

   logic [15:0] da[7] = '{16'd13, 16'hFFFF, 16'h1234, 16'hFFFD, 16'h8000, 16'h7FFF, 16'hFFFD};
   logic [7:0]  db[7] = '{8'd11, 8'hFF, 8'h00, 8'h05, 8'h80, 8'h80, 8'h05};
   bit          ds[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
   logic [23:0] dp[7] = '{24'd143, 24'hFEFF01, 24'h000000, 24'hFFFFF1, 24'h400000,
                          24'hC00080, 24'h04FFF1};

   initial begin : main
      logic [P_W-1:0] pv;
      logic [A_W-1:0] ra;
      logic [B_W-1:0] rb;
      bit rs, hold_ok, no_pulse;
      int n, m;

      rst = 1'b1; in_vld = 1'b0; out_rdy = 1'b0; a = '0; b = '0; is_signed = 1'b0;
      #1;
      chk("rst_in_rdy", in_rdy, 0);
      chk("rst_out_vld", out_vld, 0);
      chk("rst_busy", busy, 0);
      chk("rst_p", p, 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      rst_sw = 1'b0;
      #1;
      chk("rel_in_rdy", in_rdy, 1);

      for (int i = 0; i < 7; i++) begin
         run_op(da[i], db[i], ds[i], i % 3, pv);
         chk($sformatf("dir%0d_p", i), pv, dp[i]);
      end

      // Backpressure with a second request pending
      @(negedge clk);
      a = 16'd300; b = 8'd7; is_signed = 1'b0; in_vld = 1'b1;
      n = 0;
      while (!in_rdy && n < 20) begin @(negedge clk); n++; end
      @(negedge clk);
      a = 16'hFFFE; b = 8'h03; is_signed = 1'b1;
      m = 0;
      while (!out_vld && m < 20) begin @(negedge clk); m++; end
      chk("bp_lat", m, S);
      hold_ok = 1'b1;
      for (int c = 0; c < 10; c++) begin
         if (p !== 24'd2100 || out_vld !== 1'b1 || in_rdy !== 1'b0) hold_ok = 1'b0;
         @(negedge clk);
      end
      chk("bp_hold", hold_ok, 1);
      chk("bp_p", p, 24'd2100);
      out_rdy = 1'b1;
      @(negedge clk);
      out_rdy = 1'b0;
      chk("bp_not_taken_busy", busy, 0);
      chk("bp_idle_rdy", in_rdy, 1);
      @(negedge clk);
      chk("bp_taken_busy", busy, 1);
      in_vld = 1'b0;
      m = 0;
      while (!out_vld && m < 20) begin @(negedge clk); m++; end
      chk("bp2_lat", m, S);
      chk("bp2_p", p, 24'hFFFFFA);
      out_rdy = 1'b1;
      @(negedge clk);
      out_rdy = 1'b0;

      // Asynchronous reset in the middle of a calculation
      @(negedge clk);
      a = 16'h0055; b = 8'h77; is_signed = 1'b0; in_vld = 1'b1;
      n = 0;
      while (!in_rdy && n < 20) begin @(negedge clk); n++; end
      @(negedge clk);
      in_vld = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("mid_rst_p", p, 0);
      chk("mid_rst_vld", out_vld, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_rdy", in_rdy, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("post_rst_rdy", in_rdy, 1);
      no_pulse = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (out_vld !== 1'b0) no_pulse = 1'b0;
      end
      chk("post_rst_no_vld", no_pulse, 1);
      run_op(16'd6, 8'd7, 1'b0, 0, pv);
      chk("post_rst_42", pv, 24'd42);

      for (int i = 0; i < 30; i++) begin
         ra = A_W'($urandom); rb = B_W'($urandom); rs = 1'($urandom_range(1));
         run_op(ra, rb, rs, $urandom_range(3), pv);
         chk("rnd_p", pv, ref_mul(ra, rb, rs, A_W, B_W));
      end

      n = 0;
      while (!(g_sw[0].sw_done && g_sw[1].sw_done) && n < 90000) begin @(negedge clk); n++; end
      chk("sweeps_done", g_sw[0].sw_done && g_sw[1].sw_done, 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
